peripheral_mpi_line_rx: RTL and testbench

Line-side serial receiver that consumes the MPI peripheral's transmit line (mpi_txd) and recovers 8N1 frames into bytes. It sits directly downstream of the MPI peripheral, for example in a loopback or inter-tile link. It uses the same smclk_en tick as the bit-rate base. Received bytes are buffered in a small FIFO and delivered on a valid/ready stream. Framing errors and overruns are reported as sticky flags.

---
 rtl/peripheral_mpi_line_rx_pkg.sv | 19 +
 rtl/peripheral_mpi_rx_fifo.sv | 88 ++++++++
 rtl/peripheral_mpi_line_rx.sv | 152 +++++++++++++++
 tb/tb_peripheral_mpi_line_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_mpi_line_rx_pkg.sv
// Shared types and constants for the MPI line-side 8N1 receiver.
package peripheral_mpi_line_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/peripheral_mpi_rx_fifo.sv
// Small synchronous receive FIFO with a registered head byte and a drop strobe
// for pushes that find the FIFO full with no simultaneous pop.
module peripheral_mpi_rx_fifo
    import peripheral_mpi_line_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [DATA_BITS-1:0]          data_i,
    input  logic                          pop_i,
    output logic [DATA_BITS-1:0]          data_o,
    output logic                          valid_o,
    output logic [level_width(DEPTH)-1:0] level_o,
    output logic                          drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_q, rd_q, rd_next_s;
    logic [LVL_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic                 valid_q;
    logic                 full_s, push_s, pop_s;

    // Push/pop qualification and next head/level.
    always_comb begin
        rd_next_s = rd_q + PTR_W'(1);
        full_s    = (cnt_q == LVL_W'(DEPTH));
        pop_s     = pop_i & valid_q;
        push_s    = push_i & (~full_s | pop_s);
        drop_o    = push_i & full_s & ~pop_s;
        cnt_d     = cnt_q;
        head_d    = head_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + LVL_W'(1);
            2'b01:   cnt_d = cnt_q - LVL_W'(1);
            default: cnt_d = cnt_q;
        endcase
        // Head is refreshed only on a pop or on a push into an empty FIFO.
        if (pop_s) begin
            if (cnt_q > LVL_W'(1)) begin
                head_d = mem_q[rd_next_s];
            end else if (push_s) begin
                head_d = data_i;
            end else begin
                head_d = head_q;
            end
        end else if (push_s && (cnt_q == '0)) begin
            head_d = data_i;
        end else begin
            head_d = head_q;
        end
    end

    // Storage, pointers, level and head registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push_s) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_q <= rd_next_s;
            end
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= (cnt_d != '0);
        end
    end

    assign data_o  = head_q;
    assign valid_o = valid_q;
    assign level_o = cnt_q;

endmodule

// File: rtl/peripheral_mpi_line_rx.sv
// 8N1 receiver for the MPI transmit line: synchronizer, bit-timing FSM,
// shifter, sticky error flags, and a receive FIFO on a valid/ready stream.
module peripheral_mpi_line_rx
    import peripheral_mpi_line_rx_pkg::*;
#(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               mclk,
    input  logic                               puc_rst,
    input  logic                               smclk_en,
    input  logic                               mpi_rxd,
    output logic [7:0]                         rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [level_width(FIFO_DEPTH)-1:0] rx_level,
    output logic                               frame_err,
    output logic                               overrun,
    input  logic                               err_clr
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q, settle_q;
    logic                   armed_q, rxs_s;
    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   push_s, ferr_set_s, drop_s;
    logic                   frame_err_q, overrun_q;

    assign rxs_s = sync_q[SYNC_STAGES-1];

    // Line synchronizer; armed only once a genuine high level has been seen,
    // so a reset in mid-frame never starts on a data bit.
    always_ff @(posedge mclk or negedge puc_rst) begin
        if (!puc_rst) begin
            sync_q   <= '1;
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], mpi_rxd};
            settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            armed_q  <= armed_q | (settle_q[SYNC_STAGES-1] & rxs_s);
        end
    end

    // Frame FSM next-state, counters and shifter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && !rxs_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (smclk_en && (cnt_q == HALF_LAST)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_s ? IDLE : DATA;
                end else if (smclk_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DATA: begin
                if (smclk_en && (cnt_q == FULL_LAST)) begin
                    cnt_d   = '0;
                    shift_d = {rxs_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = (bit_q == LAST_BIT) ? STOP : DATA;
                end else if (smclk_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            STOP: begin
                if (smclk_en && (cnt_q == FULL_LAST)) begin
                    cnt_d      = '0;
                    push_s     = rxs_s;
                    ferr_set_s = ~rxs_s;
                    state_d    = rxs_s ? IDLE : BREAK;
                end else if (smclk_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            BREAK: begin
                if (rxs_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, counters, shifter and sticky flags (a new error beats err_clr).
    always_ff @(posedge mclk or negedge puc_rst) begin
        if (!puc_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= (frame_err_q & ~err_clr) | ferr_set_s;
            overrun_q   <= (overrun_q & ~err_clr) | drop_s;
        end
    end

    peripheral_mpi_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (mclk),
        .rst_ni  (puc_rst),
        .push_i  (push_s),
        .data_i  (shift_q),
        .pop_i   (rx_ready),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .level_o (rx_level),
        .drop_o  (drop_s)
    );

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_peripheral_mpi_line_rx.sv
// Directed bench: frames are driven on mpi_rxd, expected bytes go into a
// scoreboard queue that a forked monitor drains on every accepted byte.
module tb_peripheral_mpi_line_rx;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          mclk     = 1'b0;
    logic          puc_rst  = 1'b0;
    logic          smclk_en = 1'b1;
    logic          mpi_rxd  = 1'b1;
    logic          rx_ready = 1'b1;
    logic          err_clr  = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [LW-1:0] rx_level;
    logic          frame_err;
    logic          overrun;

    int         checks = 0;
    int         errors = 0;
    bit         slow   = 1'b0;
    logic [7:0] exp_q [$];

    always #5 mclk = ~mclk;

    peripheral_mpi_line_rx #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .mclk      (mclk),
        .puc_rst   (puc_rst),
        .smclk_en  (smclk_en),
        .mpi_rxd   (mpi_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_level  (rx_level),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        mpi_rxd = b;
        for (int i = 0; i < BAUD; i++) begin
            smclk_en = 1'b1;
            tick(1);
            if (slow) begin
                smclk_en = 1'b0;
                tick(1);
            end
        end
        smclk_en = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        send_bit(stop_bit);
    endtask

    task automatic send_byte(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, 1'b1);
        send_bit(1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rx_valid) && n < 200) begin
            tick(1);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge mclk);
            if (puc_rst && rx_valid && rx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_byte actual=%02h required=none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL rx_byte actual=%02h required=%02h", rx_data, e);
                    end
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        tick(3);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_level", 32'(rx_level), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        puc_rst = 1'b1;
        tick(10);

        // 1: single byte
        send_byte(8'hA5);
        drain("t1_drain");
        chk("t1_ferr", 32'(frame_err), 32'd0);
        chk("t1_ovr", 32'(overrun), 32'd0);
        chk("t1_level", 32'(rx_level), 32'd0);

        // 2: one-tick glitch is rejected
        mpi_rxd = 1'b0;
        tick(1);
        mpi_rxd = 1'b1;
        tick(3 * BAUD);
        chk("t2_level", 32'(rx_level), 32'd0);
        chk("t2_valid", 32'(rx_valid), 32'd0);
        chk("t2_ferr", 32'(frame_err), 32'd0);

        // 3: framing error with long break, then recovery (slow tick rate)
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send_bit(1'b0);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t3_ferr_set", 32'(frame_err), 32'd1);
        chk("t3_level", 32'(rx_level), 32'd0);
        slow = 1'b1;
        send_byte(8'h55);
        slow = 1'b0;
        drain("t3_drain");
        chk("t3_ferr_sticky", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t3_ferr_clr", 32'(frame_err), 32'd0);

        // 4: overrun with consumer stalled
        rx_ready = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            if (d <= DEPTH) begin
                exp_q.push_back(8'(d));
            end
            send_frame(8'(d), 1'b1);
            send_bit(1'b1);
        end
        chk("t4_level", 32'(rx_level), 32'd4);
        chk("t4_ovr", 32'(overrun), 32'd1);
        chk("t4_head", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        drain("t4_drain");
        chk("t4_valid", 32'(rx_valid), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t4_ovr_clr", 32'(overrun), 32'd0);

        // 5: full FIFO, pop exactly on the push cycle of byte 5
        rx_ready = 1'b0;
        for (int d = 8'h11; d <= 8'h14; d++) begin
            exp_q.push_back(8'(d));
            send_frame(8'(d), 1'b1);
            send_bit(1'b1);
        end
        chk("t5_full", 32'(rx_level), 32'd4);
        exp_q.push_back(8'h15);
        send_frame(8'h15, 1'b1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("t5_level", 32'(rx_level), 32'd4);
        chk("t5_ovr", 32'(overrun), 32'd0);
        rx_ready = 1'b1;
        drain("t5_drain");
        chk("t5_empty", 32'(rx_level), 32'd0);

        // 6: reset during data bit 3 of a zero byte, then a clean frame
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0);
        end
        mpi_rxd = 1'b0;
        tick(2);
        puc_rst = 1'b0;
        tick(2);
        chk("t6_rst_level", 32'(rx_level), 32'd0);
        puc_rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        send_byte(8'h7E);
        drain("t6_drain");
        chk("t6_ferr", 32'(frame_err), 32'd0);
        chk("t6_ovr", 32'(overrun), 32'd0);
        chk("t6_level", 32'(rx_level), 32'd0);

        tick(5);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
